// File: rtl/asip_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the fetch FSM states and the {instr, pc} entry passed between fetch stages.
package asip_fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_PC_INC  = 4;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that catches a fetch response while decode is stalled.
// Clear wins over load, and load wins over pop.
module fetch_skid_buf
  import asip_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   pop,
  input  logic   clear,
  input  entry_t din,
  output logic   valid,
  output entry_t dout
);

  logic   valid_q, valid_d;
  entry_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding memory requests,
// delivers PC-tagged instructions to decode and squashes the pipeline on a taken branch.
module fetch_unit
  import asip_fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int                PC_INC   = FETCH_PC_INC
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               PC_SRC,
  input  logic [ADDR_W-1:0]  BRANCH_TARGET,
  input  logic               STALL,
  output logic               IMEM_REQ,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  input  logic               IMEM_READY,
  input  logic               IMEM_VALID,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [INSTR_W-1:0] INSTR_OUT,
  output logic [ADDR_W-1:0]  INSTR_PC,
  output logic               INSTR_VALID,
  output logic               FLUSH
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  entry_t            out_q, out_d;
  logic              out_vld_q, out_vld_d;
  logic              flush_q, flush_d;

  logic   imem_req, accept, resp_ok, take;
  logic   skid_load, skid_pop, skid_clear, skid_valid;
  entry_t skid_dout, resp;

  fetch_skid_buf #(
    .entry_t(entry_t)
  ) u_skid (
    .clk  (CLK),
    .rst_n(RST_N),
    .load (skid_load),
    .pop  (skid_pop),
    .clear(skid_clear),
    .din  (resp),
    .valid(skid_valid),
    .dout (skid_dout)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    flush_d    = 1'b0;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;
    // A full skid blocks new requests, so every response is guaranteed a slot.
    imem_req   = (state_q == REQ) && !skid_valid;
    accept     = imem_req && IMEM_READY;
    resp_ok    = (state_q == WAIT) && IMEM_VALID;
    take       = out_vld_q && !STALL;
    resp.instr = IMEM_RDATA;
    resp.pc    = req_pc_q;

    if (state_q == BOOT) begin
      state_d = REQ;
    end else if (PC_SRC) begin
      pc_d       = BRANCH_TARGET;
      flush_d    = 1'b1;
      out_vld_d  = 1'b0;
      skid_clear = 1'b1;
      // A response landing in the redirect cycle is the one awaited; drop it and refetch.
      case (state_q)
        REQ:     state_d = accept ? DROP : REQ;
        default: state_d = IMEM_VALID ? REQ : DROP;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(PC_INC);
            state_d  = WAIT;
          end
        end
        WAIT:    if (IMEM_VALID) state_d = REQ;
        DROP:    if (IMEM_VALID) state_d = REQ;
        default: ;
      endcase

      if (take) begin
        if (skid_valid) begin
          out_d    = skid_dout;
          skid_pop = 1'b1;
        end else if (resp_ok) begin
          out_d = resp;
        end else begin
          out_vld_d = 1'b0;
        end
      end else if (resp_ok) begin
        if (out_vld_q) begin
          skid_load = 1'b1;
        end else begin
          out_d     = resp;
          out_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      flush_q   <= flush_d;
    end
  end

  assign IMEM_REQ    = imem_req;
  assign IMEM_ADDR   = pc_q;
  assign INSTR_OUT   = out_q.instr;
  assign INSTR_PC    = out_q.pc;
  assign INSTR_VALID = out_vld_q;
  assign FLUSH       = flush_q;

endmodule
